wb_writeback_unit: RTL and testbench
====================================

Name: wb_writeback_unit

Overview:
- Consumer end of the MEM/WB pipeline registers: takes every MEM_WB_* field and performs the architectural writeback.
- Aligns and extends load data, selects the register-file result, and owns the HI/LO registers.
- Drives the register-file and CP0 write ports and keeps a retired-write counter.
- Sits between the MEM/WB register outputs and the RegisterFile/COP0.

Parameters:
- DW, 32, datapath width (fixed 32; parameter for documentation only).
- CNT_W, 32, retired-write counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_stall  in  1  WB stalled this cycle; suppresses all state updates and write enables
- wcp0, whi, wlo, wreg, hi_i_sel, lo_i_sel, SC_result_sel  in  1 each  control fields from MEM/WB
- result_sel  in  2  RF result select
- load_type, byte_valid  in  4 each  load kind; lanes taken from memory for LWL/LWR
- regdst  in  5  destination register
- rf_rdata0_fw, rf_rdata1_fw, ALU_result, mem_rdata  in  32 each  rs value, rt value, address/result, raw memory word
- MulDiv_result  in  64  {hi,lo} product/quotient
- rf_we  out  1  RegisterFile write enable
- rf_waddr  out  5  write address
- rf_wdata  out  32  write data
- cp0_we  out  1  COP0 write enable
- cp0_waddr  out  5  COP0 register number
- cp0_wdata  out  32  COP0 write data
- hi_o, lo_o  out  32 each  HI/LO register values
- instret_o  out  CNT_W  retired-write count

Behaviour:
- Reset (rst=1 at posedge): hi_o=0, lo_o=0, instret_o=0.
- Combinational outputs depend only on inputs and HI/LO, so with inputs at 0 they are all 0.
- Load alignment (combinational); a = ALU_result[1:0], little-endian:
  - LB (1): sign-extend byte a of mem_rdata.
  - LBU (2): zero-extend byte a.
  - LH (3): sign-extend halfword a[1].
  - LHU (4): zero-extend halfword a[1].
  - LWL (5): s = mem_rdata << 8*(3-a); each byte lane i takes s if byte_valid[i], else rf_rdata1_fw.
  - LWR (6): s = mem_rdata >> 8*a; same per-lane merge.
  - 0 and all others: mem_rdata unchanged.
- RF write data, by result_sel:
  - 00: ALU_result.
  - 01: aligned load data.
  - 10: hi_o.
  - 11: lo_o.
  - SC_result_sel=1 overrides everything: rf_wdata=32'd1 (single-core, SC always succeeds).
- Write enables:
  - rf_we = wreg & ~wb_stall & (regdst!=0).
  - rf_waddr = regdst.
  - cp0_we = wcp0 & ~wb_stall.
  - cp0_waddr = regdst; cp0_wdata = rf_rdata1_fw.
- HI/LO update at posedge, only when wb_stall=0:
  - If whi: hi_o <= hi_i_sel ? rf_rdata0_fw : MulDiv_result[63:32].
  - If wlo: lo_o <= lo_i_sel ? rf_rdata0_fw : MulDiv_result[31:0].
  - whi and wlo together update both in the same cycle.
- MFHI/MFLO reading HI/LO in the same cycle as a whi/wlo write sees the old value; see the optional feature.
- instret_o increments by 1 when ~wb_stall & (wreg|whi|wlo|wcp0); wraps at 2^CNT_W-1 to 0.
- A flushed MEM/WB entry has all controls 0: no write, no count.
- Reset asserted mid-stream wins over any write in the same cycle.
- Stall held for N cycles: HI/LO and count unchanged; on release exactly one update occurs.

Optional Feature:
- Macro: WB_HILO_BYPASS_EN.
- Defined:
  - hi_o/lo_o present the next-state value combinationally (write value when whi/wlo & ~wb_stall).
  - The result_sel 10/11 paths use the same bypassed value.
- Undefined: hi_o/lo_o are the registered values only.

Decomposition:
- Shared package wb_pkg holds:
  - load_type encodings: LT_LW=0, LT_LB=1, LT_LBU=2, LT_LH=3, LT_LHU=4, LT_LWL=5, LT_LWR=6.
  - result_sel encodings: RS_ALU=0, RS_MEM=1, RS_HI=2, RS_LO=3.
- One sub-module, wb_load_align: purely combinational load extraction/merge taking load_type, byte_valid, addr[1:0], mem_rdata, rt_old.

Test Plan:
- LB, mem_rdata=0x80FF7F01, ALU_result=...2, result_sel=01, wreg=1, regdst=5 -> rf_we=1, rf_waddr=5, rf_wdata=0xFFFFFFFF. Same word with LBU at addr 3 -> 0x00000080.
- LWL, a=1, mem_rdata=0xAABBCCDD, byte_valid=1100, rt=0x11223344 -> rf_wdata=0xCCDD3344. LWR, a=2, byte_valid=0011, rt=0x11223344 -> 0x1122AABB.
- whi=wlo=1, sel=0, MulDiv_result=0x00000001_FFFFFFFE -> next cycle hi_o=1, lo_o=0xFFFFFFFE. Then MFHI (result_sel=10) -> rf_wdata=1.
- whi=1 with wb_stall=1 for 3 cycles -> hi_o and instret_o unchanged, rf_we=0. Release -> exactly one increment of instret_o.
- wreg=1, regdst=0 -> rf_we=0, instret_o still increments. SC_result_sel=1 -> rf_wdata=1.
- Preload instret_o to 0xFFFFFFFF via repeated writes/force, one more write -> 0. rst=1 while whi=1 -> hi_o=0.

Source files
------------

// File: rtl/wb_writeback_unit_pkg.sv
// Shared encodings for the writeback stage: load kinds and register-file result selects.
package wb_pkg;

    localparam int WB_DW = 32;

    typedef enum logic [3:0] {
        LT_LW  = 4'd0,
        LT_LB  = 4'd1,
        LT_LBU = 4'd2,
        LT_LH  = 4'd3,
        LT_LHU = 4'd4,
        LT_LWL = 4'd5,
        LT_LWR = 4'd6
    } load_type_e;

    typedef enum logic [1:0] {
        RS_ALU = 2'd0,
        RS_MEM = 2'd1,
        RS_HI  = 2'd2,
        RS_LO  = 2'd3
    } result_sel_e;

endpackage

// File: rtl/wb_writeback_unit_if.sv
// MEM/WB register fields plus the RegisterFile/COP0 write ports they produce.
interface wb_writeback_unit_if;

    logic        wb_stall;
    logic        wcp0;
    logic        whi;
    logic        wlo;
    logic        wreg;
    logic        hi_i_sel;
    logic        lo_i_sel;
    logic        SC_result_sel;
    logic [1:0]  result_sel;
    logic [3:0]  load_type;
    logic [3:0]  byte_valid;
    logic [4:0]  regdst;
    logic [31:0] rf_rdata0_fw;
    logic [31:0] rf_rdata1_fw;
    logic [31:0] ALU_result;
    logic [31:0] mem_rdata;
    logic [63:0] MulDiv_result;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;

    // master is the MEM/WB register side, slave is the writeback unit.
    modport master (
        output wb_stall, wcp0, whi, wlo, wreg, hi_i_sel, lo_i_sel, SC_result_sel,
               result_sel, load_type, byte_valid, regdst, rf_rdata0_fw, rf_rdata1_fw,
               ALU_result, mem_rdata, MulDiv_result,
        input  rf_we, rf_waddr, rf_wdata, cp0_we, cp0_waddr, cp0_wdata
    );

    modport slave (
        input  wb_stall, wcp0, whi, wlo, wreg, hi_i_sel, lo_i_sel, SC_result_sel,
               result_sel, load_type, byte_valid, regdst, rf_rdata0_fw, rf_rdata1_fw,
               ALU_result, mem_rdata, MulDiv_result,
        output rf_we, rf_waddr, rf_wdata, cp0_we, cp0_waddr, cp0_wdata
    );

endinterface

// File: rtl/wb_writeback_unit_load_align.sv
// wb_load_align: combinational little-endian load extraction and LWL/LWR lane merge.
module wb_load_align
    import wb_pkg::*;
(
    input  logic [3:0]  load_type_i,
    input  logic [3:0]  byte_valid_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] mem_rdata_i,
    input  logic [31:0] rt_old_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] lwlShift;
    logic [31:0] lwrShift;
    logic [31:0] lwlMerge;
    logic [31:0] lwrMerge;

    assign byteSel  = mem_rdata_i[{addr_i, 3'b000} +: 8];
    assign halfSel  = addr_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    assign lwlShift = mem_rdata_i << {2'd3 - addr_i, 3'b000};
    assign lwrShift = mem_rdata_i >> {addr_i, 3'b000};

    // Unaligned loads keep the old rt bytes in lanes memory does not supply.
    always_comb begin
        lwlMerge = rt_old_i;
        lwrMerge = rt_old_i;
        for (int i = 0; i < 4; i++) begin
            if (byte_valid_i[i]) begin
                lwlMerge[8*i +: 8] = lwlShift[8*i +: 8];
                lwrMerge[8*i +: 8] = lwrShift[8*i +: 8];
            end
        end
    end

    always_comb begin
        data_o = mem_rdata_i;
        case (load_type_e'(load_type_i))
            LT_LB:   data_o = {{24{byteSel[7]}}, byteSel};
            LT_LBU:  data_o = {24'd0, byteSel};
            LT_LH:   data_o = {{16{halfSel[15]}}, halfSel};
            LT_LHU:  data_o = {16'd0, halfSel};
            LT_LWL:  data_o = lwlMerge;
            LT_LWR:  data_o = lwrMerge;
            default: data_o = mem_rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_writeback_unit.sv
// Writeback stage: RF/COP0 write ports, HI/LO registers and a retired-write counter.
// Optional macro WB_HILO_BYPASS_EN exposes next-state HI/LO combinationally.
module wb_writeback_unit
    import wb_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_writeback_unit_if.slave   wb,
    output logic [DW-1:0]        hi_o,
    output logic [DW-1:0]        lo_o,
    output logic [CNT_W-1:0]     instret_o
);

    logic [DW-1:0]    hi_q, hi_d;
    logic [DW-1:0]    lo_q, lo_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [DW-1:0]    loadData;
    logic             stateUpdate;

    wb_load_align u_load_align (
        .load_type_i  (wb.load_type),
        .byte_valid_i (wb.byte_valid),
        .addr_i       (wb.ALU_result[1:0]),
        .mem_rdata_i  (wb.mem_rdata),
        .rt_old_i     (wb.rf_rdata1_fw),
        .data_o       (loadData)
    );

    assign stateUpdate = ~wb.wb_stall & (wb.wreg | wb.whi | wb.wlo | wb.wcp0);

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (wb.whi && !wb.wb_stall)
            hi_d = wb.hi_i_sel ? wb.rf_rdata0_fw : wb.MulDiv_result[63:32];
        if (wb.wlo && !wb.wb_stall)
            lo_d = wb.lo_i_sel ? wb.rf_rdata0_fw : wb.MulDiv_result[31:0];
        instret_d = stateUpdate ? instret_q + CNT_W'(1) : instret_q;
    end

`ifdef WB_HILO_BYPASS_EN
    assign hi_o = hi_d;
    assign lo_o = lo_d;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif
    assign instret_o = instret_q;

    // Stall gating lives in the next-state logic, so this block only loads or resets.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q      <= '0;
            lo_q      <= '0;
            instret_q <= '0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            instret_q <= instret_d;
        end
    end

    // Store-conditional always succeeds on this single-core design.
    always_comb begin
        wb.rf_wdata = wb.ALU_result;
        if (wb.SC_result_sel) begin
            wb.rf_wdata = 32'd1;
        end else begin
            case (result_sel_e'(wb.result_sel))
                RS_MEM:  wb.rf_wdata = loadData;
                RS_HI:   wb.rf_wdata = hi_o;
                RS_LO:   wb.rf_wdata = lo_o;
                default: wb.rf_wdata = wb.ALU_result;
            endcase
        end
    end

    assign wb.rf_we     = wb.wreg & ~wb.wb_stall & (wb.regdst != 5'd0);
    assign wb.rf_waddr  = wb.regdst;
    assign wb.cp0_we    = wb.wcp0 & ~wb.wb_stall;
    assign wb.cp0_waddr = wb.regdst;
    assign wb.cp0_wdata = wb.rf_rdata1_fw;

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Directed self-checking bench for wb_writeback_unit, plus a narrow-counter instance for wrap.
module tb_wb_writeback_unit;

    logic        clk;
    logic        rst;
    logic [31:0] hiA, loA, hiB, loB;
    logic [31:0] instretA;
    logic [3:0]  instretB;
    int          checkCount;
    int          passCount;
    logic [31:0] expCnt;

    wb_writeback_unit_if busA ();
    wb_writeback_unit_if busB ();

    wb_writeback_unit #(.DW(32), .CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb        (busA),
        .hi_o      (hiA),
        .lo_o      (loA),
        .instret_o (instretA)
    );

    wb_writeback_unit #(.DW(32), .CNT_W(4)) dutWrap (
        .clk       (clk),
        .rst       (rst),
        .wb        (busB),
        .hi_o      (hiB),
        .lo_o      (loB),
        .instret_o (instretB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic clearBus();
        busA.wb_stall = 0; busA.wcp0 = 0; busA.whi = 0; busA.wlo = 0; busA.wreg = 0;
        busA.hi_i_sel = 0; busA.lo_i_sel = 0; busA.SC_result_sel = 0; busA.result_sel = 0;
        busA.load_type = 0; busA.byte_valid = 0; busA.regdst = 0; busA.rf_rdata0_fw = 0;
        busA.rf_rdata1_fw = 0; busA.ALU_result = 0; busA.mem_rdata = 0; busA.MulDiv_result = 0;
    endtask

    // A load that writes register 5 through the memory result path.
    task automatic applyStimulus(input logic [3:0] lt, input logic [3:0] bv, input logic [31:0] alu,
                                 input logic [31:0] mem, input logic [31:0] rt);
        clearBus();
        busA.wreg = 1; busA.regdst = 5; busA.result_sel = 2'd1;
        busA.load_type = lt; busA.byte_valid = bv; busA.ALU_result = alu;
        busA.mem_rdata = mem; busA.rf_rdata1_fw = rt;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        expCnt     = 0;
        clearBus();
        busB.wb_stall = 0; busB.wcp0 = 0; busB.whi = 0; busB.wlo = 0; busB.wreg = 0;
        busB.hi_i_sel = 0; busB.lo_i_sel = 0; busB.SC_result_sel = 0; busB.result_sel = 0;
        busB.load_type = 0; busB.byte_valid = 0; busB.regdst = 0; busB.rf_rdata0_fw = 0;
        busB.rf_rdata1_fw = 0; busB.ALU_result = 0; busB.mem_rdata = 0; busB.MulDiv_result = 0;
        rst = 1;
        stepEdge();
        stepEdge();
        rst = 0;
        #1;
        checkOutput("reset_hi", hiA, 0);
        checkOutput("reset_lo", loA, 0);
        checkOutput("reset_instret", instretA, 0);
        checkOutput("idle_rf_we", busA.rf_we, 0);
        checkOutput("idle_rf_wdata", busA.rf_wdata, 0);

        applyStimulus(4'd1, 4'h0, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
        #1;
        checkOutput("lb_rf_we", busA.rf_we, 1);
        checkOutput("lb_rf_waddr", busA.rf_waddr, 5);
        checkOutput("lb_data", busA.rf_wdata, 32'hFFFF_FFFF);
        stepEdge(); expCnt++;
        checkOutput("lb_instret", instretA, expCnt);

        applyStimulus(4'd2, 4'h0, 32'h0000_0003, 32'h80FF_7F01, 32'h0);
        #1 checkOutput("lbu_data", busA.rf_wdata, 32'h0000_0080);
        stepEdge(); expCnt++;
        applyStimulus(4'd3, 4'h0, 32'h0000_0002, 32'h80FF_7F01, 32'h0);
        #1 checkOutput("lh_data", busA.rf_wdata, 32'hFFFF_80FF);
        stepEdge(); expCnt++;
        applyStimulus(4'd4, 4'h0, 32'h0000_0000, 32'h80FF_7F01, 32'h0);
        #1 checkOutput("lhu_data", busA.rf_wdata, 32'h0000_7F01);
        stepEdge(); expCnt++;
        applyStimulus(4'd0, 4'h0, 32'h0000_0003, 32'h80FF_7F01, 32'h0);
        #1 checkOutput("lw_data", busA.rf_wdata, 32'h80FF_7F01);
        stepEdge(); expCnt++;
        applyStimulus(4'd5, 4'b1100, 32'h0000_0001, 32'hAABB_CCDD, 32'h1122_3344);
        #1 checkOutput("lwl_data", busA.rf_wdata, 32'hCCDD_3344);
        stepEdge(); expCnt++;
        applyStimulus(4'd6, 4'b0011, 32'h0000_0002, 32'hAABB_CCDD, 32'h1122_3344);
        #1 checkOutput("lwr_data", busA.rf_wdata, 32'h1122_AABB);
        stepEdge(); expCnt++;
        checkOutput("loads_instret", instretA, expCnt);

        clearBus();
        busA.wcp0 = 1; busA.regdst = 12; busA.rf_rdata1_fw = 32'hDEAD_BEEF;
        #1;
        checkOutput("cp0_we", busA.cp0_we, 1);
        checkOutput("cp0_waddr", busA.cp0_waddr, 12);
        checkOutput("cp0_wdata", busA.cp0_wdata, 32'hDEAD_BEEF);
        checkOutput("cp0_rf_we", busA.rf_we, 0);
        stepEdge(); expCnt++;

        clearBus();
        busA.whi = 1; busA.wlo = 1; busA.MulDiv_result = 64'h0000_0001_FFFF_FFFE;
        #1;
`ifdef WB_HILO_BYPASS_EN
        checkOutput("hi_before_edge", hiA, 32'h1);
`else
        checkOutput("hi_before_edge", hiA, 32'h0);
`endif
        stepEdge(); expCnt++;
        checkOutput("muldiv_hi", hiA, 32'h1);
        checkOutput("muldiv_lo", loA, 32'hFFFF_FFFE);
        clearBus();
        busA.wreg = 1; busA.regdst = 3; busA.result_sel = 2'd2;
        #1 checkOutput("mfhi_data", busA.rf_wdata, 32'h1);
        busA.result_sel = 2'd3;
        #1 checkOutput("mflo_data", busA.rf_wdata, 32'hFFFF_FFFE);
        stepEdge(); expCnt++;

        clearBus();
        busA.whi = 1; busA.hi_i_sel = 1; busA.rf_rdata0_fw = 32'h1234_5678;
        stepEdge(); expCnt++;
        checkOutput("mthi_hi", hiA, 32'h1234_5678);
        checkOutput("mthi_lo_kept", loA, 32'hFFFF_FFFE);
        checkOutput("mthi_instret", instretA, expCnt);

        clearBus();
        busA.wb_stall = 1; busA.whi = 1; busA.hi_i_sel = 1; busA.rf_rdata0_fw = 32'hCAFE_F00D;
        busA.wreg = 1; busA.regdst = 4;
        for (int i = 0; i < 3; i++) begin
            #1 checkOutput("stall_rf_we", busA.rf_we, 0);
            stepEdge();
            checkOutput("stall_hi", hiA, 32'h1234_5678);
            checkOutput("stall_instret", instretA, expCnt);
        end
        busA.wb_stall = 0;
        stepEdge(); expCnt++;
        clearBus();
        checkOutput("release_hi", hiA, 32'hCAFE_F00D);
        checkOutput("release_instret", instretA, expCnt);
        stepEdge();
        checkOutput("release_once", instretA, expCnt);

        busA.wreg = 1; busA.regdst = 0;
        #1 checkOutput("r0_rf_we", busA.rf_we, 0);
        stepEdge(); expCnt++;
        checkOutput("r0_instret", instretA, expCnt);
        busA.regdst = 7; busA.ALU_result = 32'h55; busA.SC_result_sel = 1;
        #1 checkOutput("sc_data", busA.rf_wdata, 32'h1);
        stepEdge(); expCnt++;
        clearBus();
        stepEdge();
        checkOutput("flush_instret", instretA, expCnt);

        busA.whi = 1; busA.hi_i_sel = 1; busA.rf_rdata0_fw = 32'h0000_FFFF;
        rst = 1;
        stepEdge();
        rst = 0;
        clearBus();
        checkOutput("rst_wins_hi", hiA, 0);
        checkOutput("rst_wins_instret", instretA, 0);

        busB.wreg = 1; busB.regdst = 1;
        for (int i = 0; i < 15; i++) stepEdge();
        checkOutput("wrap_max", instretB, 4'hF);
        stepEdge();
        checkOutput("wrap_zero", instretB, 4'h0);
        busB.wreg = 0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
